// File: rtl/periph_pkg.sv
// Shared definitions for the GPIO/logic-analyzer peripheral family:
// packet field layout, nbytes encodings, report tag and the TX FSM states.
package periph_pkg;

    localparam int PERIPH_ADDR_WIDTH = 3;

    localparam int CFG_BIT    = 28;
    localparam int NBYTES_MSB = 27;
    localparam int NBYTES_LSB = 26;
    localparam int DATA_MSB   = 23;

    localparam logic [1:0] NBYTES_1 = 2'd1;
    localparam logic [1:0] NBYTES_2 = 2'd2;
    localparam logic [1:0] NBYTES_3 = 2'd3;

    localparam logic [7:0] REPORT_TAG = 8'hD0;

    typedef struct packed {
        logic [PERIPH_ADDR_WIDTH-1:0] addr;
        logic                         cfg;
        logic [NBYTES_MSB-NBYTES_LSB:0] nbytes;
        logic [1:0]                   rsvd;
        logic [DATA_MSB:0]            data;
    } periph_packet_t;

    typedef enum logic {
        S_DATA   = 1'b0,
        S_REPORT = 1'b1
    } tx_state_e;

    // In-band drop report: config packet tagged 0xD0 carrying the 16-bit drop count.
    function automatic periph_packet_t make_report(input logic [PERIPH_ADDR_WIDTH-1:0] addr,
                                                   input logic [15:0] drops);
        periph_packet_t p;
        p.addr   = addr;
        p.cfg    = 1'b1;
        p.nbytes = NBYTES_2;
        p.rsvd   = 2'b00;
        p.data   = {REPORT_TAG, drops};
        return p;
    endfunction

endpackage

// File: rtl/periph_tx_packer_if.sv
// Payload-in / packet-out bundle of the TX packer. The master modport is the
// packer itself; the slave modport is the peripheral core plus host arbiter.
interface periph_tx_packer_if #(
    parameter int width                = 32,
    parameter int periph_address_width = 3,
    parameter int depth                = 16
);
    logic [width-periph_address_width-1:0] payload_in;
    logic                                  payload_valid;
    logic [width-1:0]                      tx_packet;
    logic                                  tx_valid;
    logic                                  tx_ready;
    logic [$clog2(depth):0]                fifo_count;
    logic                                  overflow;
    logic                                  clear_overflow;

    modport master (
        input  payload_in, payload_valid, tx_ready, clear_overflow,
        output tx_packet, tx_valid, fifo_count, overflow
    );

    modport slave (
        output payload_in, payload_valid, tx_ready, clear_overflow,
        input  tx_packet, tx_valid, fifo_count, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Plain synchronous FIFO: memory, wrapping pointers and an occupancy count.
// Read data is the combinational head entry; no first-word-fall-through register.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/periph_tx_packer.sv
// Stamps the peripheral address onto payload words, buffers them and hands
// packets to the host arbiter, inserting a drop-count report once the FIFO drains.
module periph_tx_packer
    import periph_pkg::*;
#(
    parameter int width                = 32,
    parameter int periph_address_width = PERIPH_ADDR_WIDTH,
    parameter int depth                = 16,
    parameter logic [periph_address_width-1:0] PERIPH_ADDR = 3'd1
) (
    input  logic               clk,
    input  logic               rst,
    periph_tx_packer_if.master bus
);
    localparam int CW = $clog2(depth) + 1;

    tx_state_e        state_q, state_d;
    logic [width-1:0] tx_packet_q, tx_packet_d;
    logic             tx_valid_q, tx_valid_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;

    logic [width-1:0] fifo_rd_data;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, drop, slot_free, pop;

    // A write while full is dropped even if the output register pops this cycle.
    assign push      = bus.payload_valid && !fifo_full;
    assign drop      = bus.payload_valid && fifo_full;
    assign slot_free = !tx_valid_q || bus.tx_ready;
    assign pop       = (state_q == S_DATA) && slot_free && !fifo_empty;

    sync_fifo #(
        .WIDTH (width),
        .DEPTH (depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({PERIPH_ADDR, bus.payload_in}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_DATA;
        else     state_q <= state_d;
    end

    // Report only once the FIFO is empty, so it never overtakes buffered data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DATA:   if (drop_count_q != '0 && fifo_empty && slot_free) state_d = S_REPORT;
            S_REPORT: if (slot_free) state_d = S_DATA;
            default:  state_d = S_DATA;
        endcase
    end

    always_comb begin
        tx_packet_d  = tx_packet_q;
        tx_valid_d   = tx_valid_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;

        if (state_q == S_REPORT) begin
            if (slot_free) begin
                tx_packet_d = make_report(PERIPH_ADDR, drop_count_q);
                tx_valid_d  = 1'b1;
            end
        end else if (pop) begin
            tx_packet_d = fifo_rd_data;
            tx_valid_d  = 1'b1;
        end else if (slot_free) begin
            tx_valid_d = 1'b0;
        end

        // Clearing at the report edge keeps a same-cycle drop as the new first count.
        if (state_q == S_REPORT && slot_free) begin
            drop_count_d = drop ? 16'd1 : 16'd0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        if (drop)                    overflow_d = 1'b1;
        else if (bus.clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_packet_q  <= '0;
            tx_valid_q   <= 1'b0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            tx_packet_q  <= tx_packet_d;
            tx_valid_q   <= tx_valid_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.tx_packet  = tx_packet_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.fifo_count = fifo_count;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_periph_tx_packer.sv
// Bench for periph_tx_packer: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based model of buffer, output slot and drops.
module tb_periph_tx_packer;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    periph_tx_packer_if #(.width(32), .periph_address_width(3), .depth(DEPTH)) bus ();

    periph_tx_packer #(
        .width                (32),
        .periph_address_width (3),
        .depth                (DEPTH),
        .PERIPH_ADDR          (3'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    logic [31:0] m_pkt;
    bit          m_valid;
    int unsigned m_drops;
    bit          m_ovf;
    bit          m_report_due;

    logic [31:0] xfer_log[$];

    logic        s_valid;
    logic [31:0] s_packet;
    logic [4:0]  s_count;
    logic        s_ovf;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] report_word(input logic [15:0] n);
        return {3'd1, 1'b1, 2'b10, 2'b00, 8'hD0, n};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_pkt        = '0;
        m_valid      = 1'b0;
        m_drops      = 0;
        m_ovf        = 1'b0;
        m_report_due = 1'b0;
    endtask

    // One clock edge of the reference: buffer queue, single output slot, pending report.
    task automatic model_step(input bit valid, input logic [28:0] payload, input bit ready,
                              input bit clr, input bit r);
        int n;
        bit full;
        bit drop;
        bit slot;
        bit go;
        if (r) begin
            model_clear();
            return;
        end
        n    = mq.size();
        full = (n == DEPTH);
        drop = valid && full;
        slot = !m_valid || ready;
        if (m_report_due) begin
            if (slot) begin
                m_pkt        = report_word(m_drops[15:0]);
                m_valid      = 1'b1;
                m_drops      = drop ? 1 : 0;
                m_report_due = 1'b0;
            end else if (drop && m_drops < 65535) begin
                m_drops++;
            end
        end else begin
            go = (m_drops != 0) && (n == 0) && slot;
            if (slot && n > 0) begin
                m_pkt   = mq.pop_front();
                m_valid = 1'b1;
            end else if (slot) begin
                m_valid = 1'b0;
            end
            if (drop && m_drops < 65535) m_drops++;
            m_report_due = go;
        end
        if (valid && !full) mq.push_back({3'd1, payload});
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic applyStimulus(input bit valid, input logic [28:0] payload, input bit ready,
                                 input bit clr, input bit r);
        @(negedge clk);
        s_valid  = bus.tx_valid;
        s_packet = bus.tx_packet;
        s_count  = bus.fifo_count;
        s_ovf    = bus.overflow;
        checkOutput("tx_valid", 32'(s_valid), 32'(m_valid));
        checkOutput("fifo_count", 32'(s_count), 32'(mq.size()));
        checkOutput("overflow", 32'(s_ovf), 32'(m_ovf));
        if (m_valid) checkOutput("tx_packet", s_packet, m_pkt);
        bus.payload_valid  = valid;
        bus.payload_in     = payload;
        bus.tx_ready       = ready;
        bus.clear_overflow = clr;
        rst                = r;
        if (s_valid && ready && !r) xfer_log.push_back(s_packet);
        model_step(valid, payload, ready, clr, r);
    endtask

    task automatic idle(input int n, input bit ready);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 29'd0, ready, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 29'(k), 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] log_at(input int k);
        return (k < xfer_log.size()) ? xfer_log[k] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        rst                = 1'b1;
        bus.payload_valid  = 1'b0;
        bus.payload_in     = '0;
        bus.tx_ready       = 1'b0;
        bus.clear_overflow = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);

        // Reset state, then a single strobe with the arbiter always ready
        applyStimulus(1'b1, 29'h0800_ABCD, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_packet", s_packet, 32'h0);
        checkOutput("reset_valid", 32'(s_valid), 32'd0);
        idle(1, 1'b1);
        checkOutput("t1_n1_valid", 32'(s_valid), 32'd0);
        checkOutput("t1_n1_count", 32'(s_count), 32'd1);
        idle(1, 1'b1);
        checkOutput("t1_n2_valid", 32'(s_valid), 32'd1);
        checkOutput("t1_n2_packet", s_packet, 32'h2800_ABCD);
        idle(1, 1'b1);
        checkOutput("t1_n3_valid", 32'(s_valid), 32'd0);
        checkOutput("t1_n3_count", 32'(s_count), 32'd0);

        // Overflow with 20 strobes, then drain and expect 17 data packets plus a report
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        fill(20);
        idle(2, 1'b0);
        checkOutput("t2_count", 32'(s_count), 32'd16);
        checkOutput("t2_overflow", 32'(s_ovf), 32'd1);
        checkOutput("t2_head", s_packet, 32'h2000_0000);
        xfer_log.delete();
        idle(30, 1'b1);
        checkOutput("t2_nxfers", 32'(xfer_log.size()), 32'd18);
        for (int k = 0; k < 17; k++) checkOutput("t2_order", log_at(k), 32'h2000_0000 | 32'(k));
        checkOutput("t2_report", log_at(17), report_word(16'd3));
        checkOutput("t2_final_valid", 32'(s_valid), 32'd0);

        // Back-pressure: packet held stable, then exactly one transfer
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        xfer_log.delete();
        applyStimulus(1'b1, 29'h123_4567, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle(1, 1'b0);
            checkOutput("t3_hold_valid", 32'(s_valid), 32'd1);
            checkOutput("t3_hold_packet", s_packet, 32'h2123_4567);
        end
        idle(1, 1'b1);
        idle(1, 1'b0);
        checkOutput("t3_one_xfer", 32'(xfer_log.size()), 32'd1);
        checkOutput("t3_after_valid", 32'(s_valid), 32'd0);

        // Full FIFO with strobe and pop together: strobe is dropped
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        fill(17);
        idle(1, 1'b0);
        checkOutput("t4_full", 32'(s_count), 32'd16);
        xfer_log.delete();
        applyStimulus(1'b1, 29'h1FFF_FFFF, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        checkOutput("t4_count", 32'(s_count), 32'd15);
        checkOutput("t4_overflow", 32'(s_ovf), 32'd1);
        idle(30, 1'b1);
        checkOutput("t4_nxfers", 32'(xfer_log.size()), 32'd18);
        checkOutput("t4_report", log_at(17), report_word(16'd1));

        // clear_overflow loses to a same-cycle drop, then clears alone
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        fill(17);
        applyStimulus(1'b1, 29'h0AAA_AAAA, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_set_wins", 32'(s_ovf), 32'd1);
        idle(1, 1'b0);
        checkOutput("t5_cleared", 32'(s_ovf), 32'd0);
        idle(30, 1'b1);

        // Reset with 8 buffered entries and pending drops: nothing survives
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        fill(20);
        idle(8, 1'b1);
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_pre_count", 32'(s_count), 32'd8);
        checkOutput("t6_pre_valid", 32'(s_valid), 32'd1);
        xfer_log.delete();
        idle(1, 1'b1);
        checkOutput("t6_valid", 32'(s_valid), 32'd0);
        checkOutput("t6_count", 32'(s_count), 32'd0);
        checkOutput("t6_overflow", 32'(s_ovf), 32'd0);
        idle(10, 1'b1);
        checkOutput("t6_no_report", 32'(xfer_log.size()), 32'd0);

        // Randomized traffic, alternating congested and free-flowing arbiter phases
        for (int c = 0; c < 3000; c++) begin
            int pr;
            pr = ((c / 250) % 2 == 0) ? 20 : 85;
            applyStimulus($urandom_range(0, 99) < 60, 29'($urandom), $urandom_range(0, 99) < pr,
                          $urandom_range(0, 99) < 3, $urandom_range(0, 999) == 0);
        end
        idle(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
